// File: rtl/mem_master.sv
// Request-side controller for the 32x8 memory: sequences each single access
// through setup, strobe and hold phases and returns it on a response channel.
module mem_master #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_we,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_in,
  output logic              o_mem_read_write,
  input  logic [DATA_W-1:0] i_mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_we;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_mem_rw;

  // The strobe is driven from a register and reset asynchronously, so a reset
  // mid-write removes the write enable immediately without any glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_we      <= 1'b0;
      r_rsp_rdata   <= '0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_mem_rw      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_mem_addr    <= i_req_addr;
            r_mem_data_in <= i_req_wdata;
            r_rsp_we      <= i_req_we;
            r_req_ready   <= 1'b0;
            r_state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt    <= 4'(WAIT_CYCLES - 1);
          r_mem_rw <= r_rsp_we;
          r_state  <= S_STROBE;
        end
        S_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_mem_rw <= 1'b0;
            r_state  <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (!r_rsp_we) begin
            r_rsp_rdata <= i_mem_data_out;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_mem_rw    <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready      = r_req_ready;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_we         = r_rsp_we;
  assign o_rsp_rdata      = r_rsp_rdata;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_data_in    = r_mem_data_in;
  assign o_mem_read_write = r_mem_rw;

endmodule
